l1cache_mem_arbiter: RTL and testbench



---
 rtl/l1cache_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_l1cache_mem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1cache_mem_arbiter.sv
// Round-robin N-to-1 arbiter between L1 cache memory clients and one memory server.
// Requests pass through a single output register; responses are routed back combinationally by ID tag.
module l1cache_mem_arbiter #(
  parameter int N_CLIENTS = 2,
  parameter int ID_W      = 2,
  parameter int MAX_OUT   = 4,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 64,
  localparam int CW       = (N_CLIENTS > 2) ? $clog2(N_CLIENTS) : 1,
  localparam int DID_W    = ID_W + CW,
  localparam int CNT_W    = $clog2(MAX_OUT + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CLIENTS-1:0]        up_req_valid,
  output logic [N_CLIENTS-1:0]        up_req_ready,
  input  logic [N_CLIENTS-1:0]        up_req_we,
  input  logic [N_CLIENTS*ID_W-1:0]   up_req_id,
  input  logic [N_CLIENTS*ADDR_W-1:0] up_req_addr,
  input  logic [N_CLIENTS*LINE_W-1:0] up_req_data,
  output logic [N_CLIENTS-1:0]        up_resp_valid,
  input  logic [N_CLIENTS-1:0]        up_resp_ready,
  output logic [ID_W-1:0]             up_resp_id,
  output logic [LINE_W-1:0]           up_resp_data,
  output logic                        dn_req_valid,
  output logic                        dn_req_we,
  output logic [DID_W-1:0]            dn_req_id,
  output logic [ADDR_W-1:0]           dn_req_addr,
  output logic [LINE_W-1:0]           dn_req_data,
  input  logic                        dn_req_ready,
  input  logic                        dn_resp_valid,
  input  logic [DID_W-1:0]            dn_resp_id,
  input  logic [LINE_W-1:0]           dn_resp_data,
  output logic                        dn_resp_ready,
  output logic                        err
);

  logic                 r_req_vld_p1;
  logic                 r_req_we_p1;
  logic [DID_W-1:0]     r_req_id_p1;
  logic [ADDR_W-1:0]    r_req_addr_p1;
  logic [LINE_W-1:0]    r_req_data_p1;
  logic [CW-1:0]        r_rr_ptr;
  logic [CNT_W-1:0]     r_out_cnt [N_CLIENTS];
  logic                 r_err;

  logic [N_CLIENTS-1:0] w_elig;
  logic                 w_gnt_vld;
  logic [CW-1:0]        w_gnt;
  logic                 w_space;
  logic                 w_load;
  logic [ID_W-1:0]      w_sel_id;
  logic [N_CLIENTS-1:0] w_req_hs;
  logic [N_CLIENTS-1:0] w_resp_hs;
  logic [CW-1:0]        w_c;
  logic                 w_tag_ok;

  function automatic logic [CW-1:0] f_rr_idx(input logic [CW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_CLIENTS) s = s - N_CLIENTS;
    return CW'(s);
  endfunction

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      w_elig[i] = up_req_valid[i] && (r_out_cnt[i] < CNT_W'(MAX_OUT));
    end
  end

  // Descending scan so the client closest to the pointer wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = N_CLIENTS - 1; k >= 0; k--) begin
      if (w_elig[f_rr_idx(r_rr_ptr, k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = f_rr_idx(r_rr_ptr, k);
      end
    end
  end

  assign w_space  = !r_req_vld_p1 || dn_req_ready;
  assign w_load   = w_gnt_vld && w_space;
  assign w_sel_id = up_req_id[w_gnt*ID_W +: ID_W];

  always_comb begin
    up_req_ready = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      up_req_ready[i] = w_load && (w_gnt == CW'(i));
    end
  end

  assign w_req_hs = up_req_ready & up_req_valid;

  assign w_c      = dn_resp_id[ID_W +: CW];
  assign w_tag_ok = {1'b0, w_c} < (CW + 1)'(N_CLIENTS);

  // Unknown tags match no client, so the response is accepted and dropped.
  always_comb begin
    up_resp_valid = '0;
    dn_resp_ready = 1'b1;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (w_c == CW'(i)) begin
        up_resp_valid[i] = dn_resp_valid;
        dn_resp_ready    = up_resp_ready[i];
      end
    end
  end

  assign w_resp_hs    = up_resp_valid & up_resp_ready;
  assign up_resp_id   = dn_resp_id[ID_W-1:0];
  assign up_resp_data = dn_resp_data;

  // Stage p1: registered request toward memory
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_vld_p1  <= 1'b0;
      r_req_we_p1   <= 1'b0;
      r_req_id_p1   <= '0;
      r_req_addr_p1 <= '0;
      r_req_data_p1 <= '0;
      r_rr_ptr      <= '0;
    end else if (w_load) begin
      r_req_vld_p1  <= 1'b1;
      r_req_we_p1   <= up_req_we[w_gnt];
      r_req_id_p1   <= {w_gnt, w_sel_id};
      r_req_addr_p1 <= up_req_addr[w_gnt*ADDR_W +: ADDR_W];
      r_req_data_p1 <= up_req_data[w_gnt*LINE_W +: LINE_W];
      r_rr_ptr      <= f_rr_idx(w_gnt, 1);
    end else if (dn_req_ready) begin
      r_req_vld_p1  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
      for (int i = 0; i < N_CLIENTS; i++) r_out_cnt[i] <= '0;
    end else begin
      if (dn_resp_valid && !w_tag_ok) r_err <= 1'b1;
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (w_resp_hs[i] && (r_out_cnt[i] == '0)) r_err <= 1'b1;
        if (w_req_hs[i] && !w_resp_hs[i]) begin
          r_out_cnt[i] <= r_out_cnt[i] + CNT_W'(1);
        end else if (!w_req_hs[i] && w_resp_hs[i] && (r_out_cnt[i] != '0)) begin
          r_out_cnt[i] <= r_out_cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  assign dn_req_valid = r_req_vld_p1;
  assign dn_req_we    = r_req_we_p1;
  assign dn_req_id    = r_req_id_p1;
  assign dn_req_addr  = r_req_addr_p1;
  assign dn_req_data  = r_req_data_p1;
  assign err          = r_err;

endmodule

// File: tb/tb_l1cache_mem_arbiter.sv
// Bench for l1cache_mem_arbiter with 3 clients, 2-bit IDs and 2 outstanding per client:
// directed corner sequences, a routing table, then random traffic against a transaction-level model.
module tb_l1cache_mem_arbiter;
  localparam int N  = 3;
  localparam int IW = 2;
  localparam int MO = 2;
  localparam int AW = 32;
  localparam int LW = 64;
  localparam int DW = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    up_req_valid, up_req_ready, up_req_we;
  logic [N*IW-1:0] up_req_id;
  logic [N*AW-1:0] up_req_addr;
  logic [N*LW-1:0] up_req_data;
  logic [N-1:0]    up_resp_valid, up_resp_ready;
  logic [IW-1:0]   up_resp_id;
  logic [LW-1:0]   up_resp_data;
  logic            dn_req_valid, dn_req_we, dn_req_ready;
  logic [DW-1:0]   dn_req_id;
  logic [AW-1:0]   dn_req_addr;
  logic [LW-1:0]   dn_req_data;
  logic            dn_resp_valid, dn_resp_ready;
  logic [DW-1:0]   dn_resp_id;
  logic [LW-1:0]   dn_resp_data;
  logic            err;

  int n_chk = 0;
  int n_err = 0;

  l1cache_mem_arbiter #(.N_CLIENTS(N), .ID_W(IW), .MAX_OUT(MO), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_req_valid(up_req_valid), .up_req_ready(up_req_ready), .up_req_we(up_req_we),
    .up_req_id(up_req_id), .up_req_addr(up_req_addr), .up_req_data(up_req_data),
    .up_resp_valid(up_resp_valid), .up_resp_ready(up_resp_ready),
    .up_resp_id(up_resp_id), .up_resp_data(up_resp_data),
    .dn_req_valid(dn_req_valid), .dn_req_we(dn_req_we), .dn_req_id(dn_req_id),
    .dn_req_addr(dn_req_addr), .dn_req_data(dn_req_data), .dn_req_ready(dn_req_ready),
    .dn_resp_valid(dn_resp_valid), .dn_resp_id(dn_resp_id), .dn_resp_data(dn_resp_data),
    .dn_resp_ready(dn_resp_ready), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [DW-1:0] id;
    logic [N-1:0]  rdy;
    logic [N-1:0]  exp_uv;
    logic          exp_drdy;
  } rvec_t;
  rvec_t tbl[8];

  // reference model state
  int            m_ptr;
  int            m_cnt[N];
  logic          m_err;
  logic          m_v, m_we;
  logic [DW-1:0] m_id;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_data;
  logic [DW-1:0] memq[$];
  int            g, c, pick, ii;
  logic          space, exp_drdy, resp_hs, inc, dec;
  logic [N-1:0]  exp_rdy, exp_uv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic [IW-1:0] id,
                         input logic [AW-1:0] a, input logic [LW-1:0] d);
    up_req_valid[i]        = v;
    up_req_we[i]           = we;
    up_req_id[i*IW +: IW]  = id;
    up_req_addr[i*AW +: AW] = a;
    up_req_data[i*LW +: LW] = d;
  endtask

  task automatic idle();
    up_req_valid = '0; up_req_we = '0; up_req_id = '0; up_req_addr = '0; up_req_data = '0;
    up_resp_ready = '0; dn_req_ready = 1'b0;
    dn_resp_valid = 1'b0; dn_resp_id = '0; dn_resp_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tbl[0] = '{1'b1, 4'b0001, 3'b001, 3'b001, 1'b1};
    tbl[1] = '{1'b1, 4'b0101, 3'b001, 3'b010, 1'b0};
    tbl[2] = '{1'b1, 4'b0110, 3'b010, 3'b010, 1'b1};
    tbl[3] = '{1'b1, 4'b1011, 3'b011, 3'b100, 1'b0};
    tbl[4] = '{1'b1, 4'b1000, 3'b100, 3'b100, 1'b1};
    tbl[5] = '{1'b1, 4'b1111, 3'b000, 3'b000, 1'b1};
    tbl[6] = '{1'b0, 4'b0100, 3'b010, 3'b000, 1'b1};
    tbl[7] = '{1'b0, 4'b1101, 3'b000, 3'b000, 1'b1};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_dn_valid", 64'(dn_req_valid), 64'd0);
    chk("rst_dn_id", 64'(dn_req_id), 64'd0);
    chk("rst_dn_addr", 64'(dn_req_addr), 64'd0);
    chk("rst_dn_data", dn_req_data, 64'd0);
    chk("rst_dn_we", 64'(dn_req_we), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_up_ready", 64'(up_req_ready), 64'd0);
    rst_n = 1'b1;

    // single client read and response
    set_req(0, 1'b1, 1'b0, 2'd1, 32'h10, 64'hA5);
    dn_req_ready = 1'b1;
    #1 chk("s1_up_ready", 64'(up_req_ready), 64'b001);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 2'd0, 32'h0, 64'h0);
    chk("s1_dn_valid", 64'(dn_req_valid), 64'd1);
    chk("s1_dn_id", 64'(dn_req_id), 64'b0001);
    chk("s1_dn_addr", 64'(dn_req_addr), 64'h10);
    chk("s1_dn_data", dn_req_data, 64'hA5);
    @(negedge clk);
    chk("s1_drained", 64'(dn_req_valid), 64'd0);
    dn_resp_valid = 1'b1; dn_resp_id = 4'b0001; dn_resp_data = 64'hDEAD; up_resp_ready = 3'b001;
    #1;
    chk("s1_resp_valid", 64'(up_resp_valid), 64'b001);
    chk("s1_resp_id", 64'(up_resp_id), 64'd1);
    chk("s1_resp_data", up_resp_data, 64'hDEAD);
    chk("s1_dn_resp_ready", 64'(dn_resp_ready), 64'd1);
    @(negedge clk);
    chk("s1_err_clean", 64'(err), 64'd0);
    #1;
    @(negedge clk);
    dn_resp_valid = 1'b0;
    chk("s1_cnt_zero_err", 64'(err), 64'd1);
    do_reset();

    // round robin, all three clients valid
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 2'(i), 32'(i), 64'(i));
    dn_req_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_grant", 64'(up_req_ready), 64'(1 << (k % 3)));
      @(negedge clk);
      chk("rr_dn_tag", 64'(dn_req_id[3:2]), 64'(k % 3));
    end
    do_reset();

    // backpressure
    set_req(0, 1'b1, 1'b1, 2'd2, 32'h100, 64'h1111);
    set_req(1, 1'b1, 1'b0, 2'd3, 32'h200, 64'h2222);
    #1 chk("bp_first", 64'(up_req_ready), 64'b001);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("bp_hold_valid", 64'(dn_req_valid), 64'd1);
      chk("bp_hold_id", 64'(dn_req_id), 64'b0010);
      chk("bp_hold_addr", 64'(dn_req_addr), 64'h100);
      chk("bp_hold_data", dn_req_data, 64'h1111);
      chk("bp_hold_we", 64'(dn_req_we), 64'd1);
      #1 chk("bp_no_accept", 64'(up_req_ready), 64'b000);
      @(negedge clk);
    end
    dn_req_ready = 1'b1;
    #1 chk("bp_release_grant", 64'(up_req_ready), 64'b010);
    @(negedge clk);
    chk("bp_next_id", 64'(dn_req_id), 64'b0111);
    chk("bp_next_addr", 64'(dn_req_addr), 64'h200);
    do_reset();

    // outstanding limit
    set_req(0, 1'b1, 1'b0, 2'd0, 32'h300, 64'h3);
    dn_req_ready = 1'b1;
    #1 chk("ol_req1", 64'(up_req_ready), 64'b001);
    @(negedge clk);
    #1 chk("ol_req2", 64'(up_req_ready), 64'b001);
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 2'd1, 32'h400, 64'h4);
    #1 chk("ol_stall_other", 64'(up_req_ready), 64'b010);
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, 2'd0, 32'h0, 64'h0);
    dn_resp_valid = 1'b1; dn_resp_id = 4'b0000; up_resp_ready = 3'b001;
    #1;
    chk("ol_still_full", 64'(up_req_ready), 64'b000);
    chk("ol_resp_route", 64'(up_resp_valid), 64'b001);
    @(negedge clk);
    dn_resp_valid = 1'b0;
    #1 chk("ol_third_accept", 64'(up_req_ready), 64'b001);
    @(negedge clk);
    chk("ol_err_clean", 64'(err), 64'd0);
    do_reset();

    // error: invalid tag, then response to an idle client
    dn_resp_valid = 1'b1; dn_resp_id = 4'b1100; up_resp_ready = 3'b111;
    #1;
    chk("bad_tag_uv", 64'(up_resp_valid), 64'b000);
    chk("bad_tag_drdy", 64'(dn_resp_ready), 64'd1);
    @(negedge clk);
    dn_resp_valid = 1'b0;
    chk("bad_tag_err", 64'(err), 64'd1);
    do_reset();
    chk("err_cleared", 64'(err), 64'd0);
    dn_resp_valid = 1'b1; dn_resp_id = 4'b1000; up_resp_ready = 3'b100;
    #1 chk("zero_cnt_uv", 64'(up_resp_valid), 64'b100);
    @(negedge clk);
    dn_resp_valid = 1'b0;
    chk("zero_cnt_err", 64'(err), 64'd1);
    repeat (3) @(negedge clk);
    chk("err_sticky", 64'(err), 64'd1);

    // response routing table
    for (int k = 0; k < 8; k++) begin
      dn_resp_valid = tbl[k].v;
      dn_resp_id    = tbl[k].id;
      up_resp_ready = tbl[k].rdy;
      dn_resp_data  = {$urandom, $urandom};
      #1;
      chk("tbl_uv", 64'(up_resp_valid), 64'(tbl[k].exp_uv));
      chk("tbl_drdy", 64'(dn_resp_ready), 64'(tbl[k].exp_drdy));
      chk("tbl_id", 64'(up_resp_id), 64'(tbl[k].id[1:0]));
      chk("tbl_data", up_resp_data, dn_resp_data);
      @(negedge clk);
    end

    // asynchronous reset mid-transaction
    do_reset();
    set_req(0, 1'b1, 1'b0, 2'd1, 32'h55, 64'h55);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 2'd0, 32'h0, 64'h0);
    chk("mr_loaded", 64'(dn_req_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid_clear", 64'(dn_req_valid), 64'd0);
    chk("mr_id_clear", 64'(dn_req_id), 64'd0);
    chk("mr_addr_clear", 64'(dn_req_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn_resp_valid = 1'b1; dn_resp_id = 4'b0001; up_resp_ready = 3'b001;
    @(negedge clk);
    dn_resp_valid = 1'b0; up_resp_ready = 3'b000;
    chk("mr_stale_resp_err", 64'(err), 64'd1);
    set_req(0, 1'b1, 1'b0, 2'd0, 32'h0, 64'h0);
    set_req(1, 1'b1, 1'b0, 2'd0, 32'h0, 64'h0);
    dn_req_ready = 1'b1;
    #1 chk("mr_ptr_zero", 64'(up_req_ready), 64'b001);
    @(negedge clk);

    // random traffic against the transaction-level model
    do_reset();
    m_ptr = 0; m_err = 1'b0; m_v = 1'b0; m_we = 1'b0; m_id = '0; m_addr = '0; m_data = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    memq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_dn_valid", 64'(dn_req_valid), 64'(m_v));
      if (m_v) begin
        chk("rnd_dn_id", 64'(dn_req_id), 64'(m_id));
        chk("rnd_dn_addr", 64'(dn_req_addr), 64'(m_addr));
        chk("rnd_dn_data", dn_req_data, m_data);
        chk("rnd_dn_we", 64'(dn_req_we), 64'(m_we));
      end
      chk("rnd_err", 64'(err), 64'(m_err));

      for (int i = 0; i < N; i++)
        set_req(i, 1'(($urandom % 3) != 0), 1'($urandom), 2'($urandom), $urandom, {$urandom, $urandom});
      dn_req_ready = 1'(($urandom % 4) != 0);
      pick = -1;
      if (memq.size() > 0 && ($urandom % 2) == 1) begin
        pick = int'($urandom % memq.size());
        dn_resp_valid = 1'b1;
        dn_resp_id = memq[pick];
      end else if (($urandom % 64) == 0) begin
        dn_resp_valid = 1'b1;
        dn_resp_id = {2'b11, 2'($urandom)};
      end else begin
        dn_resp_valid = 1'b0;
        dn_resp_id = 4'($urandom);
      end
      dn_resp_data  = {$urandom, $urandom};
      up_resp_ready = 3'($urandom);
      #1;

      g = -1;
      for (int k = 0; k < N; k++) begin
        ii = (m_ptr + k) % N;
        if (g < 0 && up_req_valid[ii] && m_cnt[ii] < MO) g = ii;
      end
      space   = !m_v || dn_req_ready;
      exp_rdy = (g >= 0 && space) ? N'(1 << g) : '0;
      c       = int'(dn_resp_id[3:2]);
      exp_uv  = (dn_resp_valid && c < N) ? N'(1 << c) : '0;
      exp_drdy = (c < N) ? up_resp_ready[c] : 1'b1;
      chk("rnd_up_ready", 64'(up_req_ready), 64'(exp_rdy));
      chk("rnd_up_resp_valid", 64'(up_resp_valid), 64'(exp_uv));
      chk("rnd_dn_resp_ready", 64'(dn_resp_ready), 64'(exp_drdy));
      chk("rnd_up_resp_id", 64'(up_resp_id), 64'(dn_resp_id[1:0]));
      chk("rnd_up_resp_data", up_resp_data, dn_resp_data);

      @(posedge clk);
      resp_hs = dn_resp_valid && exp_drdy;
      if (resp_hs) begin
        if (c >= N) m_err = 1'b1;
        else if (pick >= 0) memq.delete(pick);
      end
      if (m_v && dn_req_ready) memq.push_back(m_id);
      for (int i = 0; i < N; i++) begin
        inc = (exp_rdy != '0) && (g == i);
        dec = resp_hs && (c == i);
        if (dec && m_cnt[i] == 0) m_err = 1'b1;
        if (inc && !dec) m_cnt[i]++;
        else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
      end
      if (exp_rdy != '0) begin
        m_v    = 1'b1;
        m_we   = up_req_we[g];
        m_id   = {2'(g), up_req_id[g*IW +: IW]};
        m_addr = up_req_addr[g*AW +: AW];
        m_data = up_req_data[g*LW +: LW];
        m_ptr  = (g + 1) % N;
      end else if (dn_req_ready) begin
        m_v = 1'b0;
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
